sd_data_xfer_ctrl: RTL and testbench

//  Multi-block transfer sequencer sitting directly upstream of sd_data_serial_host.

---
 rtl/sd_data_xfer_ctrl_pkg.sv | 32 +++
 rtl/sd_data_xfer_ctrl_if.sv | 40 ++++
 rtl/sd_data_xfer_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_sd_data_xfer_ctrl.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_data_xfer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sd_data_xfer_ctrl_pkg
//  Purpose  : Shared definitions for the SD data-path transfer sequencer and
//             the serial data host: block-size width, host start-command
//             encodings, the good write CRC status token and a lane-mask
//             helper.
//  Revision : 1.0  initial release
// ============================================================================
package sd_data_xfer_ctrl_pkg;

    // Width of the block-size field in bytes.
    localparam int BLKSIZE_W = 12;

    // Command presented to the serial host on its start input.
    typedef logic [1:0] xfer_start_t;

    localparam xfer_start_t XFER_START_IDLE  = 2'b00;
    localparam xfer_start_t XFER_START_WRITE = 2'b01;
    localparam xfer_start_t XFER_START_READ  = 2'b10;
    localparam xfer_start_t XFER_START_ABORT = 2'b11;

    // CRC status token bits [3:1] returned by the card after a good write.
    localparam logic [2:0] WTOKEN_OK = 3'b010;

    // Data lanes whose CRC result matters for the current bus width.
    function automatic logic [3:0] lane_mask(input logic bus_4bit);
        return bus_4bit ? 4'hF : 4'h1;
    endfunction

endpackage : sd_data_xfer_ctrl_pkg
`default_nettype wire

// File: rtl/sd_data_xfer_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : sd_data_xfer_ctrl_if
//  Purpose  : Handshake bundle between the transfer sequencer and the serial
//             data host.
//  Signals  : host_start   sequencer -> host  start command (idle/wr/rd/abort)
//             host_finish  host -> sequencer  block finished (level)
//             host_crc_s   host -> sequencer  write CRC status token
//             host_lane_ok host -> sequencer  per-lane read CRC result
//             host_wait    host -> sequencer  cycles waited for read start bit
//  Modports : master = sequencer side, slave = host side
//  Revision : 1.0  initial release
// ============================================================================
interface sd_data_xfer_ctrl_if;
    import sd_data_xfer_ctrl_pkg::*;

    xfer_start_t host_start;
    logic        host_finish;
    logic [4:0]  host_crc_s;
    logic [3:0]  host_lane_ok;
    logic [31:0] host_wait;

    modport master (
        output host_start,
        input  host_finish,
        input  host_crc_s,
        input  host_lane_ok,
        input  host_wait
    );

    modport slave (
        input  host_start,
        output host_finish,
        output host_crc_s,
        output host_lane_ok,
        output host_wait
    );

endinterface : sd_data_xfer_ctrl_if
`default_nettype wire

// File: rtl/sd_data_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sd_data_xfer_ctrl
//  Purpose  : Multi-block transfer sequencer in front of the serial data host.
//             Accepts a block-count request, gates every block on FIFO level,
//             drives the host start handshake, checks per-block CRC status /
//             lane CRC / read timeout and reports progress and sticky errors.
//  Ports    : sd_clk, rst          clock, asynchronous active-high reset
//             xfer_req/dir/blkcnt  request pulse, direction, block count
//             xfer_abort           level abort
//             blksize, bus_4bit    block size (bytes), 4-bit bus select
//             tx_level, rx_free    Tx FIFO fill / Rx FIFO free (32-bit words)
//             timeout              read start-bit timeout
//             host                 handshake bundle to the serial host
//             xfer_busy/done       transfer in progress / end-of-transfer pulse
//             blocks_done          good blocks in current transfer
//             err_wcrc/rcrc/tmo/abort  sticky error flags
//  Revision : 1.0  initial release
// ============================================================================
module sd_data_xfer_ctrl
    import sd_data_xfer_ctrl_pkg::*;
#(
    parameter int BLKCNT_W = 16,
    parameter int LEVEL_W  = 10
) (
    input  logic                 sd_clk,
    input  logic                 rst,

    input  logic                 xfer_req,
    input  logic                 xfer_dir,
    input  logic [BLKCNT_W-1:0]  xfer_blkcnt,
    input  logic                 xfer_abort,
    input  logic [BLKSIZE_W-1:0] blksize,
    input  logic                 bus_4bit,
    input  logic [LEVEL_W-1:0]   tx_level,
    input  logic [LEVEL_W-1:0]   rx_free,
    input  logic [31:0]          timeout,

    sd_data_xfer_ctrl_if.master  host,

    output logic                 xfer_busy,
    output logic                 xfer_done,
    output logic [BLKCNT_W-1:0]  blocks_done,
    output logic                 err_wcrc,
    output logic                 err_rcrc,
    output logic                 err_tmo,
    output logic                 err_abort
);

    // One-hot state encoding.
    typedef enum logic [6:0] {
        S_IDLE      = 7'b000_0001,
        S_WAIT_FIFO = 7'b000_0010,
        S_RUN       = 7'b000_0100,
        S_RELEASE   = 7'b000_1000,
        S_CHECK     = 7'b001_0000,
        S_ABORT     = 7'b010_0000,
        S_DONE      = 7'b100_0000
    } state_t;

    // Common width for comparing a FIFO level against words-per-block.
    localparam int c_cmp_w = (LEVEL_W > (BLKSIZE_W - 2)) ? LEVEL_W : (BLKSIZE_W - 2);

    state_t                r_state;
    xfer_start_t           r_host_start;
    logic                  r_dir;
    logic [BLKCNT_W-1:0]   r_blkcnt;
    logic [BLKCNT_W-1:0]   r_blocks_done;
    logic                  r_xfer_busy;
    logic                  r_xfer_done;
    logic                  r_err_wcrc;
    logic                  r_err_rcrc;
    logic                  r_err_tmo;
    logic                  r_err_abort;
    logic [2:0]            r_wtoken;       // crc_s[3:1] captured at block finish
    logic [3:0]            r_lane_ok;
    logic [31:0]           r_wait;
    logic                  r_abort_cnt;    // counts the two abort-command cycles

    logic [c_cmp_w-1:0]    w_words;
    logic [c_cmp_w-1:0]    w_level;
    logic                  w_fifo_ok;
    logic                  w_abort_hit;
    logic [3:0]            w_mask;
    logic                  w_wcrc_bad;
    logic                  w_tmo;
    logic                  w_rcrc_bad;
    logic                  w_last;
    logic                  w_unused_bits;

    // Block size is a whole number of 32-bit words; the byte offset bits
    // and the framing bits of the CRC status token carry no information.
    assign w_words       = c_cmp_w'(blksize[BLKSIZE_W-1:2]);
    assign w_level       = r_dir ? c_cmp_w'(rx_free) : c_cmp_w'(tx_level);
    assign w_fifo_ok     = (w_level >= w_words);
    assign w_unused_bits = ^{blksize[1:0], host.host_crc_s[4], host.host_crc_s[0]};

    // Abort wins over every in-flight state, including a block that finishes
    // in the same cycle. ABORT and DONE are already on their way out.
    assign w_abort_hit = xfer_abort &&
                         ((r_state == S_WAIT_FIFO) || (r_state == S_RUN) ||
                          (r_state == S_RELEASE)   || (r_state == S_CHECK));

    // Block verdict, evaluated from the snapshot taken when the host finished.
    // For reads a timeout masks any lane result: no data was received.
    assign w_mask     = lane_mask(bus_4bit);
    assign w_wcrc_bad = !r_dir && (r_wtoken != WTOKEN_OK);
    assign w_tmo      =  r_dir && (r_wait >= timeout);
    assign w_rcrc_bad =  r_dir && !w_tmo && ((r_lane_ok & w_mask) != w_mask);

    // blkcnt is never zero once latched, so this cannot underflow.
    assign w_last = (r_blocks_done == (r_blkcnt - BLKCNT_W'(1)));

    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_host_start  <= XFER_START_IDLE;
            r_dir         <= 1'b0;
            r_blkcnt      <= '0;
            r_blocks_done <= '0;
            r_xfer_busy   <= 1'b0;
            r_xfer_done   <= 1'b0;
            r_err_wcrc    <= 1'b0;
            r_err_rcrc    <= 1'b0;
            r_err_tmo     <= 1'b0;
            r_err_abort   <= 1'b0;
            r_wtoken      <= '0;
            r_lane_ok     <= '0;
            r_wait        <= '0;
            r_abort_cnt   <= 1'b0;
        end else begin
            r_xfer_done <= 1'b0;

            if (w_abort_hit) begin
                r_host_start <= XFER_START_ABORT;
                r_abort_cnt  <= 1'b0;
                r_state      <= S_ABORT;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (xfer_req) begin
                            r_dir         <= xfer_dir;
                            r_blkcnt      <= (xfer_blkcnt == '0) ? BLKCNT_W'(1) : xfer_blkcnt;
                            r_blocks_done <= '0;
                            r_err_wcrc    <= 1'b0;
                            r_err_rcrc    <= 1'b0;
                            r_err_tmo     <= 1'b0;
                            r_err_abort   <= 1'b0;
                            r_xfer_busy   <= 1'b1;
                            r_state       <= S_WAIT_FIFO;
                        end
                    end

                    // A whole block must fit before the host is started: the
                    // host cannot pause mid-block on the SD bus.
                    S_WAIT_FIFO: begin
                        if (w_fifo_ok) begin
                            r_host_start <= r_dir ? XFER_START_READ : XFER_START_WRITE;
                            r_state      <= S_RUN;
                        end
                    end

                    S_RUN: begin
                        if (host.host_finish) begin
                            r_wtoken     <= host.host_crc_s[3:1];
                            r_lane_ok    <= host.host_lane_ok;
                            r_wait       <= host.host_wait;
                            r_host_start <= XFER_START_IDLE;
                            r_state      <= S_RELEASE;
                        end
                    end

                    // Host drops finish only once it has returned to idle and
                    // can accept the next start.
                    S_RELEASE: begin
                        if (!host.host_finish) begin
                            r_state <= S_CHECK;
                        end
                    end

                    S_CHECK: begin
                        if (w_wcrc_bad) begin
                            r_err_wcrc <= 1'b1;
                            r_state    <= S_DONE;
                        end else if (w_tmo) begin
                            r_err_tmo <= 1'b1;
                            r_state   <= S_DONE;
                        end else if (w_rcrc_bad) begin
                            r_err_rcrc <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_blocks_done <= r_blocks_done + BLKCNT_W'(1);
                            r_state       <= w_last ? S_DONE : S_WAIT_FIFO;
                        end
                    end

                    // Abort command is held for two cycles so the host sees it
                    // regardless of which of its own states it is in.
                    S_ABORT: begin
                        if (!r_abort_cnt) begin
                            r_abort_cnt <= 1'b1;
                        end else begin
                            r_host_start <= XFER_START_IDLE;
                            r_err_abort  <= 1'b1;
                            r_state      <= S_DONE;
                        end
                    end

                    S_DONE: begin
                        r_xfer_done <= 1'b1;
                        r_xfer_busy <= 1'b0;
                        r_state     <= S_IDLE;
                    end

                    default: begin
                        r_host_start <= XFER_START_IDLE;
                        r_xfer_busy  <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign host.host_start = r_host_start;
    assign xfer_busy       = r_xfer_busy;
    assign xfer_done       = r_xfer_done;
    assign blocks_done     = r_blocks_done;
    assign err_wcrc        = r_err_wcrc;
    assign err_rcrc        = r_err_rcrc;
    assign err_tmo         = r_err_tmo;
    assign err_abort       = r_err_abort;

endmodule : sd_data_xfer_ctrl
`default_nettype wire

// File: tb/tb_sd_data_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sd_data_xfer_ctrl
//  Purpose  : Self-checking bench for sd_data_xfer_ctrl with a behavioural
//             serial-host model, a transaction-level outcome predictor and a
//             per-cycle protocol checker.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sd_data_xfer_ctrl;
    import sd_data_xfer_ctrl_pkg::*;

    logic        sd_clk = 1'b0;
    logic        rst    = 1'b1;
    logic        xfer_req = 1'b0;
    logic        xfer_dir = 1'b0;
    logic [15:0] xfer_blkcnt = '0;
    logic        xfer_abort = 1'b0;
    logic [11:0] blksize = 12'd512;
    logic        bus_4bit = 1'b0;
    logic [9:0]  tx_level = '0;
    logic [9:0]  rx_free = '0;
    logic [31:0] timeout = 32'd1000;

    logic        xfer_busy, xfer_done;
    logic [15:0] blocks_done;
    logic        err_wcrc, err_rcrc, err_tmo, err_abort;
    logic [3:0]  errs;
    assign errs = {err_wcrc, err_rcrc, err_tmo, err_abort};

    sd_data_xfer_ctrl_if bus();

    sd_data_xfer_ctrl #(.BLKCNT_W(16), .LEVEL_W(10)) dut (
        .sd_clk      (sd_clk),
        .rst         (rst),
        .xfer_req    (xfer_req),
        .xfer_dir    (xfer_dir),
        .xfer_blkcnt (xfer_blkcnt),
        .xfer_abort  (xfer_abort),
        .blksize     (blksize),
        .bus_4bit    (bus_4bit),
        .tx_level    (tx_level),
        .rx_free     (rx_free),
        .timeout     (timeout),
        .host        (bus),
        .xfer_busy   (xfer_busy),
        .xfer_done   (xfer_done),
        .blocks_done (blocks_done),
        .err_wcrc    (err_wcrc),
        .err_rcrc    (err_rcrc),
        .err_tmo     (err_tmo),
        .err_abort   (err_abort)
    );

    always #5 sd_clk = ~sd_clk;

    // ---------------------------------------------------------------- scoring
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------- per-block card replies
    logic [4:0]  tok_tab  [64];
    logic [3:0]  lane_tab [64];
    logic [31:0] wait_tab [64];
    int          lat_tab  [64];
    int          blk_idx = 0;

    // ------------------------------------------------------ expected outcome
    int          exp_blocks = 0;
    int          exp_starts = 0;
    logic [3:0]  exp_errs   = '0;
    logic [1:0]  exp_code   = 2'b01;
    logic        exp_dir    = 1'b0;
    bit          xfer_active = 0;
    bit          abort_armed = 0;
    bit          got_done    = 0;
    bit          lvl_rand    = 0;
    int          starts_seen = 0;

    // Outcome from the transfer rules: blocks run in order until the count is
    // reached or the first bad block, which still counts as a start.
    task automatic predict(input bit dir, input logic [15:0] cnt, input bit b4, input logic [31:0] tmo);
        int n;
        logic [3:0] m;
        n = (cnt == 16'd0) ? 1 : int'(cnt);
        m = b4 ? 4'b1111 : 4'b0001;
        exp_blocks = 0;
        exp_starts = 0;
        exp_errs   = 4'b0000;
        for (int i = 0; i < n; i++) begin
            logic [4:0] t;
            t = tok_tab[i];
            exp_starts++;
            if (!dir) begin
                if (t[3:1] != 3'b010) begin exp_errs = 4'b1000; break; end
            end else if (wait_tab[i] >= tmo) begin
                exp_errs = 4'b0010; break;
            end else if ((lane_tab[i] & m) != m) begin
                exp_errs = 4'b0100; break;
            end
            exp_blocks++;
        end
    endtask

    task automatic fill_ok();
        for (int i = 0; i < 64; i++) begin
            tok_tab[i]  = 5'b00101;
            lane_tab[i] = 4'hF;
            wait_tab[i] = 32'($urandom_range(0, 50));
            lat_tab[i]  = $urandom_range(0, 4);
        end
    endtask

    // ------------------------------------------------ behavioural serial host
    initial begin
        int hs;
        int cur;
        int lat;
        hs = 0; cur = 0; lat = 0;
        bus.host_finish  = 1'b0;
        bus.host_crc_s   = '0;
        bus.host_lane_ok = '0;
        bus.host_wait    = '0;
        forever begin
            @(posedge sd_clk); #1;
            if (rst) begin
                bus.host_finish = 1'b0;
                hs = 0;
            end else begin
                case (hs)
                    0: if (bus.host_start == 2'b01 || bus.host_start == 2'b10) begin
                           cur = blk_idx & 63;
                           blk_idx++;
                           lat = lat_tab[cur];
                           hs  = 1;
                       end
                    1: if (bus.host_start == 2'b11 || bus.host_start == 2'b00) begin
                           hs = 3;
                       end else if (lat == 0) begin
                           bus.host_finish  = 1'b1;
                           bus.host_crc_s   = tok_tab[cur];
                           bus.host_lane_ok = lane_tab[cur];
                           bus.host_wait    = wait_tab[cur];
                           hs = 2;
                       end else begin
                           lat--;
                       end
                    2: if (bus.host_start == 2'b11) begin
                           bus.host_finish = 1'b0;
                           hs = 3;
                       end else if (bus.host_start == 2'b00) begin
                           bus.host_finish = 1'b0;
                           hs = 0;
                       end
                    default: if (bus.host_start == 2'b00) hs = 0;
                endcase
            end
        end
    end

    // Random FIFO levels hovering around one block's worth of words.
    initial forever begin
        @(posedge sd_clk); #2;
        if (lvl_rand) begin
            tx_level = 10'($urandom_range(0, 2 * int'(blksize[11:2])));
            rx_free  = 10'($urandom_range(0, 2 * int'(blksize[11:2])));
        end
    end

    // ------------------------------------------------------- cycle checker
    logic        p_busy = 0, p_req = 0, p_fin = 0, p_fin_rise = 0;
    logic [1:0]  p_start = 0;
    logic [15:0] p_bd = 0;
    logic [3:0]  p_errs = 0;
    logic [9:0]  p_level = 0;
    int          run11 = 0;
    int          gap = 0;

    always @(negedge sd_clk) begin
        if (rst) begin
            chk({bus.host_start, xfer_busy, xfer_done, blocks_done, errs} == '0,
                "reset_outputs", {bus.host_start, xfer_busy, xfer_done, blocks_done, errs}, 0);
            run11 = 0;
            gap   = 0;
        end else begin
            if (p_req && !p_busy)
                chk(xfer_busy, "busy_after_req", xfer_busy, 1);
            if (!p_busy && xfer_busy) begin
                starts_seen = 0;
                run11 = 0;
                chk(blocks_done == 0 && errs == 0, "clear_on_accept", {blocks_done, errs}, 0);
            end
            chk(xfer_done == (p_busy && !xfer_busy), "done_with_busy_fall", xfer_done, p_busy && !xfer_busy);
            if (!xfer_busy)
                chk(bus.host_start == 2'b00, "idle_start", bus.host_start, 0);
            if (!xfer_busy && !p_busy)
                chk(blocks_done == p_bd && errs == p_errs, "idle_hold", {blocks_done, errs}, {p_bd, p_errs});
            if (xfer_busy && p_busy && xfer_active)
                chk(blocks_done >= p_bd && int'(blocks_done) <= exp_blocks, "blocks_progress", blocks_done, exp_blocks);
            if (xfer_busy && xfer_active)
                chk((errs & ~exp_errs) == 0, "no_spurious_err", errs, exp_errs);

            if (p_start == 2'b00 && (bus.host_start == 2'b01 || bus.host_start == 2'b10)) begin
                chk(bus.host_start == exp_code, "start_code", bus.host_start, exp_code);
                chk(p_level >= 10'(blksize[11:2]), "start_fifo_level", p_level, blksize[11:2]);
                if (starts_seen > 0) chk(gap >= 2, "block_gap", gap, 2);
                starts_seen++;
            end
            if (p_fin_rise)
                chk(bus.host_start == 2'b00 || bus.host_start == 2'b11, "start_drop_on_finish", bus.host_start, 0);

            if (bus.host_start == 2'b11) begin
                chk(abort_armed, "abort_cmd_legal", bus.host_start, 0);
                run11 = (p_start == 2'b11) ? run11 + 1 : 1;
            end else if (p_start == 2'b11) begin
                chk(run11 == 2, "abort_cmd_len", run11, 2);
                chk(bus.host_start == 2'b00, "abort_cmd_release", bus.host_start, 0);
            end

            if (xfer_done && xfer_active) begin
                chk(int'(blocks_done) == exp_blocks, "final_blocks", blocks_done, exp_blocks);
                chk(errs == exp_errs, "final_errs", errs, exp_errs);
                chk(starts_seen == exp_starts, "final_starts", starts_seen, exp_starts);
                got_done = 1;
            end

            if (bus.host_start != 2'b00 || bus.host_finish) gap = 0;
            else gap++;
        end
        p_fin_rise = bus.host_finish && !p_fin;
        p_fin   = bus.host_finish;
        p_busy  = xfer_busy;
        p_req   = xfer_req;
        p_start = bus.host_start;
        p_bd    = blocks_done;
        p_errs  = errs;
        p_level = exp_dir ? rx_free : tx_level;
    end

    // ------------------------------------------------------------- drivers
    task automatic run_xfer(input bit dir, input logic [15:0] cnt, input bit b4,
                            input logic [11:0] bs, input int abort_blk, input bit spur);
        bit spur_done;
        spur_done = 0;
        @(posedge sd_clk); #2;
        predict(dir, cnt, b4, timeout);
        exp_code    = dir ? 2'b10 : 2'b01;
        exp_dir     = dir;
        xfer_dir    = dir;
        xfer_blkcnt = cnt;
        bus_4bit    = b4;
        blksize     = bs;
        blk_idx     = 0;
        got_done    = 0;
        abort_armed = 0;
        xfer_active = 1;
        xfer_req    = 1'b1;
        @(posedge sd_clk); #2;
        xfer_req    = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (got_done) break;
            if (abort_blk >= 0 && !abort_armed && starts_seen == abort_blk + 1 &&
                (bus.host_start == 2'b01 || bus.host_start == 2'b10)) begin
                abort_armed = 1;
                exp_blocks  = abort_blk;
                exp_starts  = abort_blk + 1;
                exp_errs    = 4'b0001;
                xfer_abort  = 1'b1;
                @(posedge sd_clk); #2;
                xfer_abort  = 1'b0;
            end else if (spur && !spur_done && starts_seen == 1) begin
                // A second request while busy must be ignored.
                spur_done   = 1;
                xfer_dir    = ~dir;
                xfer_blkcnt = 16'd9;
                xfer_req    = 1'b1;
                @(posedge sd_clk); #2;
                xfer_req    = 1'b0;
            end else begin
                @(posedge sd_clk); #2;
            end
        end
        chk(got_done, "xfer_completes", got_done, 1);
        xfer_active = 0;
    endtask

    task automatic lit(input string nm, input int bd, input logic [3:0] e, input int st);
        chk(int'(blocks_done) == bd, {nm, "_blocks"}, blocks_done, bd);
        chk(errs == e, {nm, "_errs"}, errs, e);
        chk(starts_seen == st, {nm, "_starts"}, starts_seen, st);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_ok();
        repeat (3) @(posedge sd_clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge sd_clk);

        // Write 3 x 512 B, FIFO full enough, all tokens good; stray request mid-run.
        tx_level = 10'd128;
        run_xfer(1'b0, 16'd3, 1'b0, 12'd512, -1, 1'b1);
        lit("wr3", 3, 4'b0000, 3);

        // Read 2 blocks, Rx FIFO too full for 50 cycles.
        fill_ok();
        rx_free = 10'd100;
        fork
            run_xfer(1'b1, 16'd2, 1'b1, 12'd512, -1, 1'b0);
            begin
                repeat (50) @(posedge sd_clk);
                #2;
                chk(starts_seen == 0, "rd_hold_no_start", starts_seen, 0);
                rx_free = 10'd128;
            end
        join
        lit("rd2", 2, 4'b0000, 2);

        // Write 4, second block gets a bad CRC status token.
        fill_ok();
        tok_tab[1] = 5'b01011;
        run_xfer(1'b0, 16'd4, 1'b0, 12'd512, -1, 1'b0);
        lit("wcrc", 1, 4'b1000, 2);

        // Read lane check: 4-bit with lane 2 bad, then 1-bit with only lane 0 good.
        fill_ok();
        lane_tab[0] = 4'b1011;
        run_xfer(1'b1, 16'd1, 1'b1, 12'd512, -1, 1'b0);
        lit("rcrc4", 0, 4'b0100, 1);
        fill_ok();
        lane_tab[0] = 4'b0001;
        run_xfer(1'b1, 16'd1, 1'b0, 12'd512, -1, 1'b0);
        lit("rcrc1", 1, 4'b0000, 1);

        // Card silent: wait counter reached the timeout exactly.
        fill_ok();
        timeout     = 32'd100;
        wait_tab[0] = 32'd100;
        lat_tab[0]  = 8;
        run_xfer(1'b1, 16'd2, 1'b1, 12'd512, -1, 1'b0);
        lit("tmo", 0, 4'b0010, 1);
        timeout = 32'd1000;

        // Abort during the second block.
        fill_ok();
        lat_tab[1] = 6;
        run_xfer(1'b0, 16'd4, 1'b0, 12'd512, 1, 1'b0);
        lit("abort", 1, 4'b0001, 2);

        // Block count of zero moves one block.
        fill_ok();
        run_xfer(1'b0, 16'd0, 1'b0, 12'd64, -1, 1'b0);
        lit("cnt0", 1, 4'b0000, 1);

        // Reset in the middle of a block.
        fill_ok();
        lat_tab[0] = 10;
        @(posedge sd_clk); #2;
        predict(1'b0, 16'd3, 1'b0, timeout);
        exp_code = 2'b01; exp_dir = 1'b0; xfer_dir = 1'b0; xfer_blkcnt = 16'd3;
        blk_idx = 0; got_done = 0; abort_armed = 0; xfer_active = 1;
        xfer_req = 1'b1;
        @(posedge sd_clk); #2;
        xfer_req = 1'b0;
        for (int c = 0; c < 200 && bus.host_start == 2'b00; c++) begin
            @(posedge sd_clk); #2;
        end
        chk(bus.host_start == 2'b01, "rst_pre_run", bus.host_start, 2'b01);
        rst = 1'b1;
        #1;
        chk({bus.host_start, xfer_busy, xfer_done, blocks_done, errs} == '0, "rst_midrun",
            {bus.host_start, xfer_busy, xfer_done, blocks_done, errs}, 0);
        repeat (2) @(posedge sd_clk);
        #2;
        xfer_active = 0;
        rst = 1'b0;
        repeat (2) @(posedge sd_clk);

        // Randomized transfers.
        lvl_rand = 1;
        for (int t = 0; t < 30; t++) begin
            bit          dir, b4;
            logic [15:0] cnt;
            logic [11:0] bs;
            dir = 1'($urandom_range(0, 1));
            b4  = 1'($urandom_range(0, 1));
            cnt = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
            bs  = 12'(4 * $urandom_range(1, 128));
            timeout = 32'($urandom_range(20, 200));
            for (int i = 0; i < 64; i++) begin
                tok_tab[i] = ($urandom_range(0, 9) == 0) ? 5'($urandom)
                                                         : {1'($urandom), 3'b010, 1'($urandom)};
                lane_tab[i] = ($urandom_range(0, 9) == 0) ? 4'($urandom)
                                                          : (b4 ? 4'hF : (4'($urandom) | 4'h1));
                wait_tab[i] = ($urandom_range(0, 9) == 0) ? timeout + 32'($urandom_range(0, 3))
                                                          : 32'($urandom_range(0, int'(timeout) - 1));
                lat_tab[i]  = $urandom_range(0, 4);
            end
            run_xfer(dir, cnt, b4, bs, -1, 1'b0);
        end
        lvl_rand = 0;

        repeat (3) @(posedge sd_clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_sd_data_xfer_ctrl
`default_nettype wire
